// File: rtl/ff256ct_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ff256ct_pkg
// Description : Shared types, constants and coefficient tables for the
//               streaming GF(2^8) cosine transform.
// Revision    : 1.0 - initial release
// ============================================================================
// Matrix definition: C = D*P*D with P[k][i] = binom(i,k) mod 2 (upper
// triangular Pascal matrix, self-inverse over GF(2)) and D = diag(a^k),
// a = x the field generator. The inverse is D^-1*P*D^-1, so both entries
// reduce to a power a^(+/-(k+i)) gated by the Lucas condition (k & i) == k.
// Leading NxN blocks of an upper-triangular pair stay mutual inverses,
// so one table pair serves every legal N.
package ff256ct_pkg;

    localparam logic [7:0] FF256CT_POLY    = 8'h1D;
    localparam int         FF256CT_N_MIN   = 2;
    localparam int         FF256CT_N_MAX   = 16;
    localparam int         FF256CT_POW_LEN = 2 * FF256CT_N_MAX - 1;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } ff256ct_state_e;

    // Multiply by the generator x modulo x^8 + POLY
    function automatic logic [7:0] ff256ct_mul_x(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? FF256CT_POLY : 8'h00);
    endfunction

    // Divide by the generator x; POLY bit 0 is always set for a field poly
    function automatic logic [7:0] ff256ct_div_x(input logic [7:0] a);
        return a[0] ? ({1'b0, a[7:1]} ^ {1'b1, FF256CT_POLY[7:1]})
                    : {1'b0, a[7:1]};
    endfunction

    // Elaboration-time table of a^e (or a^-e) for e = 0 .. 2*N_MAX-2
    function automatic logic [8*FF256CT_POW_LEN-1:0] ff256ct_gen_pow(input logic inv);
        logic [8*FF256CT_POW_LEN-1:0] tbl;
        logic [7:0]                   v;
        tbl = '0;
        v   = 8'h01;
        for (int e = 0; e < FF256CT_POW_LEN; e++) begin
            tbl[8*e +: 8] = v;
            v = inv ? ff256ct_div_x(v) : ff256ct_mul_x(v);
        end
        return tbl;
    endfunction

    localparam logic [8*FF256CT_POW_LEN-1:0] FF256CT_POW_FWD = ff256ct_gen_pow(1'b0);
    localparam logic [8*FF256CT_POW_LEN-1:0] FF256CT_POW_INV = ff256ct_gen_pow(1'b1);

    // Coefficient C[k][i] (inv = 0) or Cinv[k][i] (inv = 1) for length n_len
    function automatic logic [7:0] ff256ct_coef(input int n_len, input logic inv,
                                                input int k, input int i);
        int e;
        if (n_len < FF256CT_N_MIN || n_len > FF256CT_N_MAX) return 8'h00;
        if (k < 0 || i < 0 || k >= n_len || i >= n_len)     return 8'h00;
        if ((k & i) != k)                                    return 8'h00;
        e = k + i;
        return inv ? FF256CT_POW_INV[8*e +: 8] : FF256CT_POW_FWD[8*e +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ff256_gf_mult.sv
`default_nettype none
// ============================================================================
// Module      : ff256_gf_mult
// Description : Combinational general 8x8 -> 8 GF(2^8) multiplier,
//               reduction polynomial x^8 + POLY.
// Revision    : 1.0 - initial release
// ============================================================================
module ff256_gf_mult
    import ff256ct_pkg::*;
#(
    parameter logic [7:0] POLY = FF256CT_POLY
) (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    logic [7:0] w_sum;
    logic [7:0] w_shift;

    // Shift-and-add: accumulate a*x^j for every set bit j of b
    always_comb begin
        w_sum   = 8'h00;
        w_shift = a;
        for (int j = 0; j < 8; j++) begin
            if (b[j]) w_sum = w_sum ^ w_shift;
            w_shift = {w_shift[6:0], 1'b0} ^ (w_shift[7] ? POLY : 8'h00);
        end
        p = w_sum;
    end

endmodule
`default_nettype wire

// File: rtl/ff256_stream_cos_transf.sv
`default_nettype none
// ============================================================================
// Module      : ff256_stream_cos_transf
// Description : Streaming N-point GF(2^8) cosine transform with per-frame
//               forward/inverse select and a double-buffered result.
// Revision    : 1.0 - initial release
// ============================================================================
// Coefficients come from the package tables, which are built for the
// package POLY; keep POLY at its default unless the tables are rebuilt.
module ff256_stream_cos_transf
    import ff256ct_pkg::*;
#(
    parameter int         N     = 8,
    parameter logic [7:0] POLY  = FF256CT_POLY,
    parameter int         CNT_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       x_in,
    input  logic             inv,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8*N-1:0]   x_out,
    output logic             busy
);

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(N - 1);

    ff256ct_state_e     r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_inv_q;
    logic [7:0]         r_acc [N];
    logic [8*N-1:0]     r_out_buf;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_consume;
    logic               w_buf_free;
    logic               w_first;
    logic               w_last;
    logic               w_inv_sel;
    logic [7:0]         w_coef [N];
    logic [7:0]         w_prod [N];
    logic [7:0]         w_next [N];
    logic [8*N-1:0]     w_next_flat;
    logic [8*N-1:0]     w_acc_flat;

    assign in_ready   = rst_n & (r_state == ACCUM);
    assign out_valid  = r_out_valid;
    assign x_out      = r_out_valid ? r_out_buf : '0;
    assign busy       = (r_cnt != '0) | (r_state == HOLD);

    assign w_accept   = in_valid & in_ready;
    assign w_consume  = r_out_valid & out_ready;
    assign w_buf_free = ~r_out_valid | out_ready;
    assign w_first    = (r_cnt == '0);
    assign w_last     = (r_cnt == c_last_cnt);
    // Symbol 0 uses the live select; later symbols use the latched one
    assign w_inv_sel  = w_first ? inv : r_inv_q;

    // One multiplier per output row; symbol 0 overwrites the stale sum
    for (genvar k = 0; k < N; k++) begin : g_row
        assign w_coef[k] = ff256ct_coef(N, w_inv_sel, k, int'(r_cnt));

        ff256_gf_mult #(
            .POLY (POLY)
        ) u_mult (
            .a (w_coef[k]),
            .b (x_in),
            .p (w_prod[k])
        );

        assign w_next[k]              = w_first ? w_prod[k] : (r_acc[k] ^ w_prod[k]);
        assign w_next_flat[8*k +: 8]  = w_next[k];
        assign w_acc_flat[8*k +: 8]   = r_acc[k];
    end

    // Accumulate / hold state machine with the output double buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) r_acc[k] <= 8'h00;
            r_cnt       <= '0;
            r_inv_q     <= 1'b0;
            r_state     <= ACCUM;
            r_out_buf   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // Consume clears valid; a load below on the same edge overrides it
            if (w_consume) r_out_valid <= 1'b0;

            case (r_state)
                ACCUM: begin
                    if (flush) begin
                        r_cnt <= '0;
                    end else if (w_accept) begin
                        if (w_first) r_inv_q <= inv;
                        if (w_last) begin
                            if (w_buf_free) begin
                                r_out_buf   <= w_next_flat;
                                r_out_valid <= 1'b1;
                                r_cnt       <= '0;
                            end else begin
                                for (int k = 0; k < N; k++) r_acc[k] <= w_next[k];
                                r_state <= HOLD;
                            end
                        end else begin
                            for (int k = 0; k < N; k++) r_acc[k] <= w_next[k];
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (w_buf_free) begin
                        r_out_buf   <= w_acc_flat;
                        r_out_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ff256_stream_cos_transf.sv
`default_nettype none
// ============================================================================
// Module      : tb_ff256_stream_cos_transf
// Description : Self-checking bench for ff256_stream_cos_transf: directed
//               latency/backpressure/flush/reset cases plus random round
//               trips at N = 4, 8, 16 against a log/antilog field model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ff256_stream_cos_transf;

    localparam int N = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       x_in;
    logic             inv;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [8*N-1:0]   x_out;
    logic             busy;

    int               n_cmp = 0;
    int               n_err = 0;
    logic [7:0]       gf_exp [0:255];
    int               gf_log [0:255];
    logic [127:0]     exp_q [$];
    bit               or_rand = 1'b0;
    logic             rt_rst_n;

    always #5 clk = ~clk;

    ff256_stream_cos_transf #(.N(N)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .inv       (inv),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .busy      (busy)
    );

    // Antilog / log tables for GF(2^8) with x^8 + x^4 + x^3 + x^2 + 1
    initial begin
        logic [7:0] v;
        v = 8'h01;
        for (int e = 0; e < 255; e++) begin
            gf_exp[e] = v;
            gf_log[v] = e;
            v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
        end
        gf_exp[255] = 8'h01;
        gf_log[0]   = 0;
    end

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return gf_exp[(gf_log[a] + gf_log[b]) % 255];
    endfunction

    // C = D*P*D and its inverse D^-1*P*D^-1, D = diag(a^k), P = Pascal mod 2
    function automatic logic [7:0] m_coef(input bit iv, input int k, input int i);
        if ((k & i) != k) return 8'h00;
        return iv ? gf_exp[(255 - (k + i)) % 255] : gf_exp[k + i];
    endfunction

    function automatic logic [127:0] ref_xform(input logic [127:0] xs, input int n, input bit iv);
        logic [127:0] y;
        y = '0;
        for (int k = 0; k < n; k++)
            for (int i = 0; i < n; i++)
                y[8*k +: 8] = y[8*k +: 8] ^ m_mul(m_coef(iv, k, i), xs[8*i +: 8]);
        return y;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] s, input bit iv);
        int t;
        t        = 0;
        in_valid = 1'b1;
        x_in     = s;
        inv      = iv;
        while (!in_ready && t < 1000) begin
            tick();
            t++;
        end
        if (!in_ready) chk("push_timeout", 128'(in_ready), 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [127:0] xs, input bit iv,
                              input logic [127:0] ex, input bit gaps);
        exp_q.push_back(ex);
        for (int s = 0; s < N; s++) begin
            push(xs[8*s +: 8], (s == 0) ? iv : 1'($urandom_range(0, 1)));
            if (gaps && $urandom_range(0, 3) == 0) tick();
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && t < 200) begin
            tick();
            t++;
        end
        chk("drain_empty", 128'(exp_q.size()), 0);
    endtask

    // Output monitor: scoreboard on consume, stability while stalled, zero when idle
    logic [8*N-1:0] prev_out;
    bit             prev_stall = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                chk("hold_valid", 128'(out_valid), 1);
                chk("hold_data", 128'(x_out), 128'(prev_out));
            end
            if (!out_valid) chk("xout_zero", 128'(x_out), 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("extra_out", 128'(out_valid), 0);
                else                   chk("frame_out", 128'(x_out), exp_q.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = x_out;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Random consumer backpressure during the random phase
    always @(posedge clk) begin
        #1;
        if (or_rand) out_ready = ($urandom_range(0, 1) == 1);
    end

    // Independent round-trip instances at N = 4 and N = 16
    initial begin
        rt_rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rt_rst_n = 1'b1;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_rt
        localparam int NS = (gi == 0) ? 4 : 16;
        logic            vld;
        logic            rdy;
        logic            ivs;
        logic            ovl;
        logic            bsy;
        logic [7:0]      xi;
        logic [8*NS-1:0] xo;
        bit              done = 1'b0;

        ff256_stream_cos_transf #(.N(NS)) u_dut (
            .clk       (clk),
            .rst_n     (rt_rst_n),
            .in_valid  (vld),
            .in_ready  (rdy),
            .x_in      (xi),
            .inv       (ivs),
            .flush     (1'b0),
            .out_valid (ovl),
            .out_ready (1'b1),
            .x_out     (xo),
            .busy      (bsy)
        );

        initial begin
            logic [127:0] xs;
            logic [127:0] ys;
            logic [127:0] mask;
            vld  = 1'b0;
            xi   = 8'h00;
            ivs  = 1'b0;
            mask = (128'd1 << (8*NS)) - 128'd1;
            @(posedge rt_rst_n);
            @(posedge clk);
            #1;
            for (int f = 0; f < 100; f++) begin
                xs = {$urandom, $urandom, $urandom, $urandom};
                xs = xs & mask;
                ys = ref_xform(xs, NS, 1'b0);
                for (int pass = 0; pass < 2; pass++) begin
                    for (int s = 0; s < NS; s++) begin
                        int t;
                        t   = 0;
                        vld = 1'b1;
                        xi  = (pass == 0) ? xs[8*s +: 8] : ys[8*s +: 8];
                        ivs = (s == 0) ? (pass == 1) : 1'($urandom_range(0, 1));
                        while (!rdy && t < 100) begin
                            @(posedge clk);
                            #1;
                            t++;
                        end
                        @(posedge clk);
                        #1;
                    end
                    vld = 1'b0;
                    chk($sformatf("rt%0d_valid", NS), 128'(ovl), 1);
                    chk($sformatf("rt%0d_pass%0d", NS, pass), 128'(xo), (pass == 0) ? ys : xs);
                end
            end
            chk($sformatf("rt%0d_idle", NS), 128'(bsy), 0);
            done = 1'b1;
        end
    end

    // Main directed + random sequence on the N = 8 instance
    initial begin
        logic [127:0] a, b, ra, rb;
        int t;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        x_in      = 8'h00;
        inv       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 0);
        chk("rst_in_ready", 128'(in_ready), 0);
        chk("rst_x_out", 128'(x_out), 0);
        chk("rst_busy", 128'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", 128'(in_ready), 1);

        // Zero frame and output latency
        out_ready = 1'b1;
        exp_q.push_back('0);
        for (int s = 0; s < N - 1; s++) push(8'h00, 1'b0);
        chk("lat_pre", 128'(out_valid), 0);
        chk("busy_mid", 128'(busy), 1);
        push(8'h00, 1'b0);
        chk("lat_valid", 128'(out_valid), 1);
        chk("zero_out", 128'(x_out), 0);
        tick();

        // Impulses at symbol 0 and symbol 3 select matrix columns
        a = 128'h01;
        send_frame(a, 1'b0, ref_xform(a, N, 1'b0), 1'b0);
        a = 128'h01 << 24;
        send_frame(a, 1'b0, ref_xform(a, N, 1'b0), 1'b0);
        drain();

        // Random forward/inverse round trips under random backpressure
        or_rand = 1'b1;
        for (int f = 0; f < 100; f++) begin
            a = 128'({$urandom, $urandom});
            b = ref_xform(a, N, 1'b0);
            send_frame(a, 1'b0, b, 1'b1);
            send_frame(b, 1'b1, a, 1'b1);
        end
        or_rand = 1'b0;
        drain();

        // Backpressure: second frame parks in HOLD, one consume swaps them
        out_ready = 1'b0;
        a  = 128'({$urandom, $urandom});
        b  = 128'({$urandom, $urandom});
        ra = ref_xform(a, N, 1'b0);
        rb = ref_xform(b, N, 1'b0);
        send_frame(a, 1'b0, ra, 1'b0);
        chk("bp_a_valid", 128'(out_valid), 1);
        send_frame(b, 1'b0, rb, 1'b0);
        chk("bp_hold_ready", 128'(in_ready), 0);
        chk("bp_hold_busy", 128'(busy), 1);
        chk("bp_a_data", 128'(x_out), ra);
        repeat (3) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_b_valid", 128'(out_valid), 1);
        chk("bp_b_data", 128'(x_out), rb);
        chk("bp_ready_back", 128'(in_ready), 1);
        drain();

        // Flush after 5 symbols with a pending result held in out_buf
        out_ready = 1'b0;
        a  = 128'({$urandom, $urandom});
        ra = ref_xform(a, N, 1'b1);
        send_frame(a, 1'b1, ra, 1'b0);
        for (int s = 0; s < 5; s++) push(8'($urandom), 1'b0);
        chk("pre_flush_busy", 128'(busy), 1);
        flush    = 1'b1;
        in_valid = 1'b1;
        x_in     = 8'hA5;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_busy", 128'(busy), 0);
        chk("flush_keep_valid", 128'(out_valid), 1);
        chk("flush_keep_data", 128'(x_out), ra);
        b  = 128'({$urandom, $urandom});
        rb = ref_xform(b, N, 1'b0);
        send_frame(b, 1'b0, rb, 1'b0);
        chk("flush_then_hold", 128'(in_ready), 0);
        drain();

        // Let the round-trip instances finish before the shared clock stops mattering
        t = 0;
        while (!(g_rt[0].done && g_rt[1].done) && t < 20000) begin
            tick();
            t++;
        end
        chk("rt_done", 128'({g_rt[0].done, g_rt[1].done}), 128'(2'b11));

        // Asynchronous reset mid-frame with a pending result
        out_ready = 1'b0;
        a = 128'({$urandom, $urandom});
        send_frame(a, 1'b0, ref_xform(a, N, 1'b0), 1'b0);
        for (int s = 0; s < 3; s++) push(8'($urandom), 1'b0);
        in_valid = 1'b1;
        x_in     = 8'h5A;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 128'(out_valid), 0);
        chk("arst_x_out", 128'(x_out), 0);
        chk("arst_ready", 128'(in_ready), 0);
        chk("arst_busy", 128'(busy), 0);
        exp_q.delete();
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        out_ready = 1'b1;
        b = 128'({$urandom, $urandom});
        send_frame(b, 1'b0, ref_xform(b, N, 1'b0), 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound
    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/ff256_stream_cos_transf.md
Name: ff256_stream_cos_transf

Overview:
Parametrised streaming GF(2^8) cosine transform. It computes X_out[k] = XOR over i of C[k][i]·x[i], for k,i in 0..N-1.
- Input symbols arrive one per accepted handshake, in order x0..x(N-1).
- Forward and inverse matrices are selectable per frame.
- The result vector is double-buffered behind a valid/ready output, so the next frame can accumulate while the previous result waits.
- It sits between the symbol framer and the downstream FF256CT consumers, and succeeds the fixed-size, 8-symbol, non-handshaked transform.

Parameters:
N, 8, transform length in symbols; legal range 2..16.
POLY, 8'h1D, low byte of the field reduction polynomial (x^8 + POLY).
CNT_W, $clog2(N), width of the symbol counter (derived; do not override).

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  x_in is valid this cycle
in_ready  out  1  block accepts x_in this cycle
x_in  in  8  input symbol
inv  in  1  matrix select, sampled with symbol 0 of a frame: 0 = forward, 1 = inverse
flush  in  1  synchronous abort of the frame being accumulated
out_valid  out  1  x_out holds a complete result
out_ready  in  1  consumer accepts x_out
x_out  out  8*N  result vector; X_out[k] occupies bits [8k+7:8k]
busy  out  1  a frame is partially accumulated (cnt != 0 or state HOLD)

Behaviour:
- Reset (rst_n low, asynchronous):
  - acc[*] = 0, cnt = 0, inv_q = 0, state = ACCUM.
  - out_buf = 0, out_valid = 0, in_ready = 0 while rst_n is low.
  - Reset mid-frame discards both the partial frame and any unconsumed result.
- Handshakes:
  - An input is accepted when in_valid & in_ready.
  - An output is consumed when out_valid & out_ready.
  - x_out is forced to 0 whenever out_valid = 0. No high-Z drive.
- Coefficients: coef = ff256ct_coef(N, inv_sel, k, cnt), where inv_sel = inv on symbol 0 and inv_q thereafter.
- Accept with cnt == 0:
  - acc[k] <= C[k][0]·x_in, overwriting the stale accumulator.
  - inv_q <= inv.
- Accept with 0 < cnt < N-1: acc[k] <= acc[k] ^ C[k][cnt]·x_in.
- Accept with cnt == N-1 (final value F[k] = acc[k] ^ C[k][N-1]·x_in):
  - If out_buf is free (out_valid = 0, or consumed this same cycle): out_buf <= F, out_valid <= 1, cnt <= 0.
  - Otherwise: acc <= F, state <= HOLD.
- Counter: cnt increments on each accept and wraps N-1 -> 0.
- Latency: the last symbol accepted at edge t gives out_valid = 1 after edge t, i.e. visible in cycle t+1.
- Throughput: one frame per N cycles under no backpressure.
- States:
  - ACCUM: in_ready = 1.
  - HOLD: in_ready = 0. When out_buf frees (consumed, or out_valid = 0): out_buf <= acc, out_valid <= 1, cnt <= 0, state <= ACCUM. Leaving HOLD takes exactly the edge at which the consume happens, so no bubble is added beyond it.
- out_valid deassertion: clears on consume unless a new result loads on the same edge; in that case it stays 1 with new data.
- flush:
  - In ACCUM: cnt <= 0, and any accept in the same cycle is ignored.
  - In HOLD: ignored, because the frame is already complete.
  - Never touches out_buf or out_valid.
- Arithmetic:
  - Addition is XOR.
  - Multiplication is full GF(2^8) modulo x^8+POLY.
  - There is no overflow.
- Protocol rule: once out_valid is high, out_buf stays stable until consumed. The verifier asserts this.

Decomposition:
- Package ff256ct_pkg:
  - ff256ct_coef(n_len, inv, k, i) function, backed by generated tables for N in 2..16.
  - Default POLY constant.
  - State enum {ACCUM, HOLD}.
- Sub-module ff256_gf_mult (#POLY): combinational 8x8 -> 8 general multiplier, instantiated N times, one per row.
- The existing constant multipliers are not reused, because the coefficient varies per cycle.

Test Plan:
- Zero frame (N=8, inv=0): x = 8×0x00 -> x_out = 0, out_valid rises exactly one cycle after the 8th accept.
- Impulse (N=8, inv=0): x0 = 0x01, rest 0 -> X[k] = ff256ct_coef(8,0,k,0) for all k. Repeat with x3 = 0x01 -> column 3.
- Round trip: random x with inv=0, then feed the result back with inv=1 -> x_out equals the original x. Run N = 4, 8, 16 with 100 random frames each.
- Backpressure: out_ready = 0, two back-to-back frames -> frame 2's 8th symbol is accepted and the block enters HOLD with in_ready = 0. Raising out_ready for one cycle gives frame 1 consumed and frame 2 visible the next cycle, with out_valid never dropping.
- Flush: flush pulsed after 5 accepted symbols, then a fresh frame -> the result matches the fresh frame only, and out_buf is unchanged meanwhile.
- Async reset: rst_n pulsed low mid-cycle during the 4th symbol with a pending result -> out_valid = 0 and x_out = 0 immediately. After release, a full frame computes correctly.
